// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_generator
//  Purpose  : Period/duty PWM with clamped signed duty input, per-period
//             sample strobe and a graceful stop that finishes the current period.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_generator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [31:0]      control,
    input  logic             invert,
    output logic             pwm,
    output logic             sample,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             busy
);

    // Width wide enough to compare a sign-extended control with period+1.
    localparam int c_cmp_w = (CNT_W + 2 > 33) ? CNT_W + 2 : 33;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] r_period_act;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W:0]   r_duty_act;
    logic [CNT_W:0]   w_duty_nxt;

    logic             w_load;
    logic             w_at_end;
    logic             w_pwm_nxt;

    logic [CNT_W:0]       w_lim;
    logic [c_cmp_w-1:0]   w_ctrl_ext;
    logic [c_cmp_w-1:0]   w_lim_ext;
    logic                 w_ctrl_neg;
    logic                 w_ctrl_over;
    logic [CNT_W:0]       w_duty_sat;

    // Saturation of the incoming request against the period being loaded.
    assign w_lim       = {1'b0, period} + {{CNT_W{1'b0}}, 1'b1};
    assign w_ctrl_ext  = {{(c_cmp_w-32){control[31]}}, control};
    assign w_lim_ext   = {{(c_cmp_w-CNT_W-1){1'b0}}, w_lim};
    assign w_ctrl_neg  = control[31];
    assign w_ctrl_over = !w_ctrl_neg && (w_ctrl_ext > w_lim_ext);

    always_comb begin
        w_duty_sat = w_ctrl_ext[CNT_W:0];
        if (w_ctrl_neg) begin
            w_duty_sat = '0;
        end else if (w_ctrl_over) begin
            w_duty_sat = w_lim;
        end
    end

    assign w_at_end = (r_count == r_period_act);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_period_nxt = r_period_act;
        w_duty_nxt   = r_duty_act;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_at_end) begin
                    w_load = 1'b1;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (!en) begin
                    w_state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (w_at_end) begin
                    if (en) begin
                        w_state_nxt = ST_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                    if (en) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase

        if (w_load) begin
            w_count_nxt  = '0;
            w_period_nxt = period;
            w_duty_nxt   = w_duty_sat;
        end
    end

    // pwm is decided from the next count/duty so it lines up with the count.
    always_comb begin
        w_pwm_nxt = invert;
        if (w_state_nxt != ST_IDLE) begin
            w_pwm_nxt = ({1'b0, w_count_nxt} < w_duty_nxt) ^ invert;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_period_act <= '0;
            r_duty_act   <= '0;
            pwm          <= 1'b0;
            sample       <= 1'b0;
            sat_hi       <= 1'b0;
            sat_lo       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_period_act <= w_period_nxt;
            r_duty_act   <= w_duty_nxt;
            pwm          <= w_pwm_nxt;
            sample       <= w_load;
            if (w_load) begin
                sat_hi <= w_ctrl_over;
                sat_lo <= w_ctrl_neg;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
